// File: rtl/trn_tx_arb.sv
// Purpose : round-robin arbiter and output mux that lets NREQ requesters share one TRN tx port.
//           Ports: req_ep/drv_ep/tag_inc (per requester), req_* TRN buses (flattened), trn_* to the core.
// Latency : grant registered, 1 cycle after request in IDLE; data path combinational from owner.
// Backpr. : trn_tdst_rdy_n broadcast unchanged to all requesters; trn_tbuf_av == 0 blocks new grants.
module trn_tx_arb #(
  parameter int NREQ     = 3,
  parameter int GRANT_TO = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_ep,
  input  logic [NREQ-1:0]      drv_ep,
  input  logic [NREQ-1:0]      tag_inc,
  output logic [NREQ-1:0]      my_trn,
  output logic [4:0]           tag_trn,
  input  logic [64*NREQ-1:0]   req_td,
  input  logic [8*NREQ-1:0]    req_trem_n,
  input  logic [NREQ-1:0]      req_tsof_n,
  input  logic [NREQ-1:0]      req_teof_n,
  input  logic [NREQ-1:0]      req_tsrc_rdy_n,
  output logic [NREQ-1:0]      req_tdst_rdy_n,
  output logic [63:0]          trn_td,
  output logic [7:0]           trn_trem_n,
  output logic                 trn_tsof_n,
  output logic                 trn_teof_n,
  output logic                 trn_tsrc_rdy_n,
  input  logic                 trn_tdst_rdy_n,
  input  logic [3:0]           trn_tbuf_av
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(GRANT_TO + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_GUARD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] my_q, my_d;
  logic [4:0]      tag_q, tag_d;
  logic [WW-1:0]   wd_q, wd_d;

  logic [IW-1:0]   pick;
  logic            found;
  logic            active;

  // Round-robin search: start one past the previous owner and wrap, so the
  // previous owner is considered last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req_ep[(int'(last_q) + i) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(last_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    my_d    = my_q;
    tag_d   = tag_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        my_d = '0;
        if (found && (trn_tbuf_av != 4'd0)) begin
          own_d   = pick;
          my_d    = NREQ'(1) << pick;
          wd_d    = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (wd_q != WW'(GRANT_TO)) wd_d = wd_q + 1'b1;
        if (drv_ep[own_q]) begin
          state_d = S_BUSY;
        end else if (!req_ep[own_q] || (wd_q >= WW'(GRANT_TO - 1))) begin
          // Withdrawn request or watchdog expiry: give the port back.
          state_d = S_GUARD;
          my_d    = '0;
        end
      end
      S_BUSY: begin
        if (tag_inc[own_q]) tag_d = tag_q + 5'd1;
        if (!drv_ep[own_q]) begin
          state_d = S_GUARD;
          my_d    = '0;
        end
      end
      S_GUARD: begin
        // One dead cycle between owners; pointer advances only here.
        last_d  = own_q;
        my_d    = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        my_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      own_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      my_q    <= '0;
      tag_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      my_q    <= my_d;
      tag_q   <= tag_d;
      wd_q    <= wd_d;
    end
  end

  assign my_trn         = my_q;
  assign tag_trn        = tag_q;
  assign req_tdst_rdy_n = {NREQ{trn_tdst_rdy_n}};

  // Mux decided purely from registered state, so an async reset idles the
  // port in the same cycle.
  assign active = (state_q == S_BUSY) || ((state_q == S_GRANT) && drv_ep[own_q]);

  assign trn_td         = active ? req_td[int'(own_q)*64 +: 64]    : 64'd0;
  assign trn_trem_n     = active ? req_trem_n[int'(own_q)*8 +: 8]  : 8'hFF;
  assign trn_tsof_n     = active ? req_tsof_n[own_q]               : 1'b1;
  assign trn_teof_n     = active ? req_teof_n[own_q]               : 1'b1;
  assign trn_tsrc_rdy_n = active ? req_tsrc_rdy_n[own_q]           : 1'b1;

endmodule

// File: tb/tb_trn_tx_arb.sv
// Purpose : directed self-checking bench for trn_tx_arb (vector table plus corner sequences).
// Latency : checks sampled 1 ns after the falling edge, inputs driven on the falling edge.
// Backpr. : trn_tdst_rdy_n toggled in the TLP sequence; trn_tbuf_av gating exercised.
module tb_trn_tx_arb;

  logic         clk;
  logic         rst;
  logic [2:0]   req_ep, drv_ep, tag_inc;
  logic [2:0]   my_trn;
  logic [4:0]   tag_trn;
  logic [191:0] req_td;
  logic [23:0]  req_trem_n;
  logic [2:0]   req_tsof_n, req_teof_n, req_tsrc_rdy_n;
  logic [2:0]   req_tdst_rdy_n;
  logic [63:0]  trn_td;
  logic [7:0]   trn_trem_n;
  logic         trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic         trn_tdst_rdy_n;
  logic [3:0]   trn_tbuf_av;

  int checks   = 0;
  int failures = 0;

  logic [63:0] td_pat [3];
  logic [7:0]  trem_pat [3];

  trn_tx_arb #(.NREQ(3), .GRANT_TO(16)) dut (
    .clk(clk), .rst(rst),
    .req_ep(req_ep), .drv_ep(drv_ep), .tag_inc(tag_inc),
    .my_trn(my_trn), .tag_trn(tag_trn),
    .req_td(req_td), .req_trem_n(req_trem_n),
    .req_tsof_n(req_tsof_n), .req_teof_n(req_teof_n), .req_tsrc_rdy_n(req_tsrc_rdy_n),
    .req_tdst_rdy_n(req_tdst_rdy_n),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] req;
    logic [2:0] drv;
    logic [2:0] tinc;
    logic [2:0] tsrc_n;
    logic [2:0] exp_my;
    logic       exp_tsrc;
    int         exp_src;   // 0..2 = owner data visible, 3 = idle values
    logic [4:0] exp_tag;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_td"},   trn_td, 64'd0);
    chk({nm, "_trem"}, {56'd0, trn_trem_n}, {56'd0, 8'hFF});
    chk({nm, "_sof"},  {63'd0, trn_tsof_n}, 64'd1);
    chk({nm, "_eof"},  {63'd0, trn_teof_n}, 64'd1);
    chk({nm, "_src"},  {63'd0, trn_tsrc_rdy_n}, 64'd1);
  endtask

  task automatic wait_grant(input string nm, input logic [2:0] exp);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk); #1;
      if (my_trn === exp) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout actual=%b expected=%b", nm, my_trn, exp);
    end
  endtask

  task automatic idle_inputs();
    req_ep         = 3'b000;
    drv_ep         = 3'b000;
    tag_inc        = 3'b000;
    req_tsof_n     = 3'b111;
    req_teof_n     = 3'b111;
    req_tsrc_rdy_n = 3'b111;
    trn_tdst_rdy_n = 1'b0;
    trn_tbuf_av    = 4'd1;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk({nm, "_rst_my"},  {61'd0, my_trn}, 64'd0);
    chk({nm, "_rst_tag"}, {59'd0, tag_trn}, 64'd0);
    chk_idle({nm, "_rst"});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle({nm, "_post"});
  endtask

  initial begin
    int cnt;
    int beats;
    logic [63:0] etd;
    logic [7:0]  etrem;

    td_pat[0] = 64'h0000_0000_AAAA_0000;
    td_pat[1] = 64'h1111_1111_BBBB_1111;
    td_pat[2] = 64'h2222_2222_CCCC_2222;
    trem_pat[0] = 8'h00;
    trem_pat[1] = 8'h0F;
    trem_pat[2] = 8'h3F;
    req_td     = {td_pat[2], td_pat[1], td_pat[0]};
    req_trem_n = {trem_pat[2], trem_pat[1], trem_pat[0]};
    rst = 1'b0;
    idle_inputs();

    //            req     drv     tinc    tsrc_n  exp_my  tsrc  src tag
    tbl[0]  = '{3'b111, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd0};
    tbl[1]  = '{3'b111, 3'b001, 3'b000, 3'b110, 3'b001, 1'b0, 0, 5'd0};
    tbl[2]  = '{3'b111, 3'b001, 3'b101, 3'b010, 3'b001, 1'b0, 0, 5'd0};
    tbl[3]  = '{3'b110, 3'b000, 3'b000, 3'b111, 3'b001, 1'b1, 0, 5'd1};
    tbl[4]  = '{3'b110, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd1};
    tbl[5]  = '{3'b110, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd1};
    tbl[6]  = '{3'b110, 3'b010, 3'b000, 3'b101, 3'b010, 1'b0, 1, 5'd1};
    tbl[7]  = '{3'b100, 3'b000, 3'b000, 3'b111, 3'b010, 1'b1, 1, 5'd1};
    tbl[8]  = '{3'b100, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd1};
    tbl[9]  = '{3'b100, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd1};
    tbl[10] = '{3'b100, 3'b000, 3'b000, 3'b011, 3'b100, 1'b1, 3, 5'd1};
    tbl[11] = '{3'b100, 3'b100, 3'b000, 3'b011, 3'b100, 1'b0, 2, 5'd1};
    tbl[12] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b100, 1'b1, 2, 5'd1};
    tbl[13] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd1};
    tbl[14] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd1};
    tbl[15] = '{3'b001, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd1};
    tbl[16] = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b001, 1'b1, 3, 5'd1};
    tbl[17] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd1};
    tbl[18] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 3, 5'd1};

    // Round-robin over three simultaneous requesters, guard cycles, withdrawal.
    do_reset("tbl");
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      req_ep         = tbl[i].req;
      drv_ep         = tbl[i].drv;
      tag_inc        = tbl[i].tinc;
      req_tsrc_rdy_n = tbl[i].tsrc_n;
      #1;
      etd   = (tbl[i].exp_src == 3) ? 64'd0 : td_pat[tbl[i].exp_src];
      etrem = (tbl[i].exp_src == 3) ? 8'hFF : trem_pat[tbl[i].exp_src];
      chk($sformatf("tbl%0d_my", i),   {61'd0, my_trn}, {61'd0, tbl[i].exp_my});
      chk($sformatf("tbl%0d_src", i),  {63'd0, trn_tsrc_rdy_n}, {63'd0, tbl[i].exp_tsrc});
      chk($sformatf("tbl%0d_td", i),   trn_td, etd);
      chk($sformatf("tbl%0d_trem", i), {56'd0, trn_trem_n}, {56'd0, etrem});
      chk($sformatf("tbl%0d_tag", i),  {59'd0, tag_trn}, {59'd0, tbl[i].exp_tag});
    end

    // Requester 1 sends a 4-beat TLP under toggling back-pressure while
    // requester 0 asserts source-ready without owning the port.
    do_reset("tlp");
    @(negedge clk);
    req_ep = 3'b010;
    req_tsrc_rdy_n = 3'b110;
    #1;
    chk_idle("tlp_nonowner");
    wait_grant("tlp_grant", 3'b010);
    drv_ep = 3'b010;
    req_tsrc_rdy_n = 3'b100;
    req_tsof_n = 3'b101;
    beats = 0;
    for (int k = 0; k < 12 && beats < 4; k++) begin
      trn_tdst_rdy_n = k[0];
      #1;
      chk($sformatf("tlp%0d_td", k), trn_td, td_pat[1]);
      chk($sformatf("tlp%0d_src", k), {63'd0, trn_tsrc_rdy_n}, 64'd0);
      chk($sformatf("tlp%0d_sof", k), {63'd0, trn_tsof_n}, {63'd0, (beats != 0)});
      chk($sformatf("tlp%0d_dst", k), {61'd0, req_tdst_rdy_n}, {61'd0, {3{k[0]}}});
      if (!trn_tdst_rdy_n) beats++;
      @(negedge clk);
      req_tsof_n = (beats != 0) ? 3'b111 : 3'b101;
    end
    chk("tlp_beats", beats, 4);
    drv_ep = 3'b000;
    req_ep = 3'b000;
    req_tsrc_rdy_n = 3'b110;
    #1;
    chk("tlp_end_src", {63'd0, trn_tsrc_rdy_n}, 64'd1);

    // Watchdog: requester 2 never drives; grant revoked after 16 GRANT cycles.
    do_reset("wd");
    @(negedge clk);
    req_ep = 3'b100;
    wait_grant("wd_grant", 3'b100);
    req_ep = 3'b101;
    cnt = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (my_trn === 3'b100) cnt++;
      else break;
    end
    chk("wd_len", cnt, 16);
    chk("wd_guard", {61'd0, my_trn}, 64'd0);
    @(negedge clk); #1;
    chk("wd_idle", {61'd0, my_trn}, 64'd0);
    @(negedge clk); #1;
    chk("wd_next", {61'd0, my_trn}, 64'd1);
    req_ep = 3'b000;

    // Tag counter wrap and non-owner pulse rejection.
    do_reset("tag");
    @(negedge clk);
    req_ep = 3'b001;
    wait_grant("tag_grant", 3'b001);
    drv_ep = 3'b001;
    @(negedge clk);
    for (int i = 0; i < 31; i++) begin
      tag_inc = 3'b001;
      @(negedge clk);
    end
    tag_inc = 3'b000;
    #1;
    chk("tag_31", {59'd0, tag_trn}, 64'd31);
    tag_inc = 3'b010;
    @(negedge clk);
    tag_inc = 3'b000;
    #1;
    chk("tag_nonowner", {59'd0, tag_trn}, 64'd31);
    tag_inc = 3'b001;
    @(negedge clk);
    tag_inc = 3'b000;
    #1;
    chk("tag_wrap", {59'd0, tag_trn}, 64'd0);
    drv_ep = 3'b000;
    req_ep = 3'b000;

    // Buffer availability gating.
    do_reset("buf");
    @(negedge clk);
    trn_tbuf_av = 4'd0;
    req_ep = 3'b001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("buf_hold%0d", i), {61'd0, my_trn}, 64'd0);
    end
    trn_tbuf_av = 4'd1;
    @(negedge clk); #1;
    chk("buf_grant", {61'd0, my_trn}, 64'd1);

    // Reset asserted during beat 2 of a TLP.
    do_reset("mid");
    @(negedge clk);
    req_ep = 3'b001;
    wait_grant("mid_grant", 3'b001);
    drv_ep = 3'b001;
    req_tsrc_rdy_n = 3'b110;
    @(negedge clk);
    tag_inc = 3'b001;
    @(negedge clk);
    tag_inc = 3'b000;
    #1;
    chk("mid_tag_pre", {59'd0, tag_trn}, 64'd1);
    chk("mid_src_pre", {63'd0, trn_tsrc_rdy_n}, 64'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_src", {63'd0, trn_tsrc_rdy_n}, 64'd1);
    chk("mid_my", {61'd0, my_trn}, 64'd0);
    chk("mid_tag", {59'd0, tag_trn}, 64'd0);
    chk("mid_td", trn_td, 64'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trn_tx_arb.md
TRN_TX_ARB -- requirements
Module: trn_tx_arb

Interface
REQ-001 Parameter: NREQ, default 3, number of TRN tx requesters (index 0 = rx path, 1 = tx path, 2 = irq/msg path).
REQ-002 Parameter: GRANT_TO, default 16, cycles a granted requester has to raise drv_ep before the grant is revoked.
REQ-003 clk  in  1  PCIe user clock; all logic rising-edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req_ep  in  NREQ  per-requester request for the TRN tx port.
REQ-006 drv_ep  in  NREQ  per-requester "currently driving" indication; held high across whole TLPs.
REQ-007 tag_inc  in  NREQ  per-requester one-cycle pulse: a non-posted tag was consumed.
REQ-008 my_trn  out  NREQ  one-hot grant, registered.
REQ-009 tag_trn  out  5  shared non-posted tag value.
REQ-010 req_td / req_trem_n  in  64*NREQ / 8*NREQ  flattened per-requester TRN data / remainder.
REQ-011 req_tsof_n, req_teof_n, req_tsrc_rdy_n  in  NREQ each  per-requester framing and valid.
REQ-012 trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n  out  64,8,1,1,1  muxed TRN tx to core.
REQ-013 trn_tdst_rdy_n  in  1  core back-pressure; also broadcast unchanged to all requesters.
REQ-014 trn_tbuf_av  in  4  core buffer availability; used only for grant gating.

Function
REQ-015 FSM states: IDLE, GRANT, BUSY, GUARD; owner index register own; round-robin pointer last.
REQ-016 IDLE: if any req_ep[i] high and trn_tbuf_av != 0, pick the first requesting index after last (wrapping NREQ-1 -> 0), load own, set my_trn[own] next edge, go GRANT.
REQ-017 IDLE with trn_tbuf_av == 0: no grant issued; my_trn stays 0.
REQ-018 GRANT: drv_ep[own] high -> BUSY; req_ep[own] low with drv_ep[own] low -> GUARD (withdrawn); watchdog reaching GRANT_TO cycles -> GUARD.
REQ-019 BUSY: remain while drv_ep[own] high; on drv_ep[own] low -> GUARD, my_trn cleared the following edge.
REQ-020 GUARD: exactly one cycle, my_trn = 0, last <= own, then IDLE; guarantees one dead cycle between owners.
REQ-021 Grant latency: req_ep rising in IDLE -> my_trn high 1 cycle later (registered).
REQ-022 No preemption: drv_ep/req_ep of other requesters never alter own outside IDLE.
REQ-023 Output mux: in BUSY (and GRANT when drv_ep[own] high) TRN outputs equal owner's req_* inputs combinationally; otherwise trn_td = 0, trn_trem_n = 8'hFF, trn_tsof_n = trn_teof_n = trn_tsrc_rdy_n = 1.
REQ-024 Source-ready from a non-owner never reaches trn_tsrc_rdy_n.
REQ-025 tag_trn increments by 1 (mod 32, 31 -> 0) on the edge after tag_inc[own] is high while state is BUSY; tag_inc from non-owners or outside BUSY is ignored.
REQ-026 Simultaneous requests: strict round-robin; after owner k, priority order is k+1, k+2, ... wrapping.
REQ-027 drv_ep[own] falling and new requests in the same cycle: GUARD first; new grant no earlier than 2 cycles after drv_ep fall.
REQ-028 Watchdog counter: ceil(log2(GRANT_TO+1)) bits, cleared on entry to GRANT, saturates.

Reset
REQ-029 rst low asynchronously forces state IDLE, my_trn = 0, own = 0, last = NREQ-1 (first grant favours index 0), tag_trn = 0, watchdog = 0.
REQ-030 During reset and in the first cycle after release, TRN outputs are idle values per REQ-023.
REQ-031 Reset asserted mid-TLP: outputs go idle immediately (combinational from state), no completion of the TLP.

Verification
REQ-032 All three req_ep raised together after reset -> my_trn = 001, then 010, then 100 across three transactions, one GUARD cycle between each.
REQ-033 Requester 1 granted, drives 4-beat TLP with trn_tdst_rdy_n toggling -> trn_td equals req_td[127:64] on every beat, requester 0's tsrc_rdy_n = 0 never visible.
REQ-034 Grant to requester 2, drv_ep never raised -> my_trn[2] drops after 16 cycles in GRANT, next requester granted 2 cycles later.
REQ-035 tag_trn = 31, owner pulses tag_inc in BUSY -> tag_trn = 0; non-owner tag_inc pulse -> tag_trn unchanged.
REQ-036 trn_tbuf_av = 0 with req_ep = 001 -> no grant; trn_tbuf_av set to 1 -> my_trn = 001 one cycle later.
REQ-037 rst pulsed low during BUSY beat 2 -> same-cycle trn_tsrc_rdy_n = 1, my_trn = 0, tag_trn = 0.
